freq_scan_ctrl: RTL and testbench
=================================

Name: freq_scan_ctrl

Overview:
Multi-channel frequency measurement sequencer. It time-shares a single gated edge counter across NUM_CH Pmod inputs and steps through the enabled channels in ascending order. For each channel it opens a GATE_TICKS-cycle counting window and publishes a tagged result. It sits between the Pmod input pins and the display/readout logic, and replaces one counter instance per pin.

Parameters:
NUM_CH, 4, number of input channels (2..16)
GATE_TICKS, 10000, CLK cycles per gate window (100000000 on hardware = 1 s at 100 MHz)
CNT_W, 12, result width in bits
CH_W, 2, channel index width; must satisfy 2**CH_W >= NUM_CH

Ports:
CLK  input  1  100 MHz system clock; all logic is on the rising edge
RST  input  1  asynchronous, active-high reset
IN  input  NUM_CH  raw asynchronous signals from the Pmod pins
START  input  1  single-cycle request to begin a scan pass; only acted on in IDLE
CONTINUOUS  input  1  1 = restart a new pass automatically after the last enabled channel
CH_MASK  input  NUM_CH  enabled channels; bit i enables IN[i]
BUSY  output  1  high in every state except IDLE
FREQ  output  CNT_W  rising-edge count from the most recent gate window
CH_ID  output  CH_W  channel index that FREQ belongs to
FREQ_VALID  output  1  one-cycle pulse; FREQ and CH_ID are new in that cycle
OVERFLOW  output  1  qualified by FREQ_VALID; the count saturated
DONE  output  1  one-cycle pulse at the end of a non-continuous pass

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0. Reset asserted mid-gate aborts the gate immediately and discards the partial result.
- Input path: IN[CH] is selected by the active channel, passed through a 2-flop synchronizer, then a "last" flop. A rising edge is counted when sync=1 and last=0.
- States:
  - IDLE: if START=1 and CH_MASK≠0, latch CH_MASK into mask_q, set CH = lowest set bit of mask_q, go to SETTLE. If START=1 and CH_MASK=0, ignore it: no BUSY, no DONE.
  - SETTLE: lasts exactly 3 cycles to flush the synchronizer and last flop after the mux change. No counting. Then go to GATE with tick=0 and edge count=0.
  - GATE: lasts exactly GATE_TICKS cycles. An edge detected in any gate cycle, including the first and last, is counted. The count saturates at 2**CNT_W-1 and sets a sticky ovf flag. Then go to STORE.
  - STORE: lasts 1 cycle. FREQ = count, CH_ID = CH, OVERFLOW = ovf, FREQ_VALID = 1 in this cycle. Edges in this cycle are not counted.
  - Channel selection after STORE:
    - If a set bit of mask_q exists above CH: move CH to the next such bit and go to SETTLE.
    - Else, if CONTINUOUS=1: re-latch CH_MASK. If the new mask is nonzero, wrap CH to its lowest set bit and go to SETTLE. If it is zero, go to IDLE and pulse DONE.
    - Else: pulse DONE (coincident with the cycle after STORE) and go to IDLE.
- Latency: START sampled at edge T gives BUSY=1 from T+1, FREQ_VALID for the first channel in cycle T+4+GATE_TICKS, and each further channel 4+GATE_TICKS cycles later.
- FREQ/CH_ID/OVERFLOW hold their value until the next STORE.
- START while BUSY is ignored. CH_MASK changes mid-pass are ignored until the next latch.
- CONTINUOUS dropped mid-pass: the current pass completes, then DONE and IDLE.
- Single enabled channel with CONTINUOUS=1: that channel is re-measured back-to-back, with SETTLE between windows.

Optional Feature:
FREQ_SCAN_IRQ_EN
- Defined: adds input IRQ_CLR (1 bit) and output IRQ (1 bit).
  - IRQ is set on DONE or on FREQ_VALID with OVERFLOW=1.
  - IRQ is cleared by IRQ_CLR=1 and resets to 0.
  - If set and clear coincide, set wins.
- Not defined: neither port exists and the behaviour is otherwise identical.

Test Plan:
- GATE_TICKS=100, CH_MASK=4'b0001, IN[0] period 10 cycles, START pulse at edge T -> BUSY at T+1; FREQ_VALID at T+104 with FREQ=10, CH_ID=0, OVERFLOW=0; DONE the next cycle; BUSY=0.
- CH_MASK=4'b1010, IN[1] period 4, IN[3] period 20 -> two FREQ_VALID pulses 104 cycles apart: (CH_ID=1, FREQ=25) then (CH_ID=3, FREQ=5); channels 0 and 2 are never reported.
- CNT_W=4, IN[0] period 2 (50 edges) -> FREQ=15, OVERFLOW=1 on that FREQ_VALID; with FREQ_SCAN_IRQ_EN, IRQ=1 until IRQ_CLR.
- CONTINUOUS=1, CH_MASK=4'b0001, then CH_MASK changed to 4'b0100 mid-gate -> the current result is still CH_ID=0; the next result is CH_ID=2; CONTINUOUS deasserted -> exactly one DONE after the current window.
- START with CH_MASK=0 -> BUSY, FREQ_VALID and DONE stay 0. START pulsed while BUSY -> no extra results.
- RST asserted at tick 50 of a gate -> all outputs 0 immediately; no FREQ_VALID; a new START after RST release yields a full, correct window.

Source files
------------

// File: rtl/freq_scan_ctrl_if.sv
// freq_scan_ctrl_if: signal bundle between the Pmod pins/readout logic and
// the frequency scan sequencer.
//   master : drives IN, START, CONTINUOUS, CH_MASK (and IRQ_CLR); observes results
//   slave  : the sequencer itself
// Optional macro FREQ_SCAN_IRQ_EN adds IRQ_CLR / IRQ.
interface freq_scan_ctrl_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 12,
   parameter int CH_W   = 2
);
   logic [NUM_CH-1:0] IN;
   logic              START;
   logic              CONTINUOUS;
   logic [NUM_CH-1:0] CH_MASK;
   logic              BUSY;
   logic [CNT_W-1:0]  FREQ;
   logic [CH_W-1:0]   CH_ID;
   logic              FREQ_VALID;
   logic              OVERFLOW;
   logic              DONE;
`ifdef FREQ_SCAN_IRQ_EN
   logic              IRQ_CLR;
   logic              IRQ;
`endif

   modport master (
      output IN, START, CONTINUOUS, CH_MASK,
      input  BUSY, FREQ, CH_ID, FREQ_VALID, OVERFLOW, DONE
`ifdef FREQ_SCAN_IRQ_EN
      , output IRQ_CLR, input IRQ
`endif
   );

   modport slave (
      input  IN, START, CONTINUOUS, CH_MASK,
      output BUSY, FREQ, CH_ID, FREQ_VALID, OVERFLOW, DONE
`ifdef FREQ_SCAN_IRQ_EN
      , input IRQ_CLR, output IRQ
`endif
   );
endinterface

// File: rtl/freq_scan_ctrl.sv
// freq_scan_ctrl: time-shares one gated edge counter across NUM_CH inputs,
// stepping through enabled channels in ascending order and publishing one
// tagged count per GATE_TICKS-cycle window.
// Ports:
//   CLK  system clock (rising edge)
//   RST  asynchronous active-high reset
//   bus  freq_scan_ctrl_if.slave (IN, START, CONTINUOUS, CH_MASK in;
//        BUSY, FREQ, CH_ID, FREQ_VALID, OVERFLOW, DONE out)
// Optional macro FREQ_SCAN_IRQ_EN: IRQ set on DONE or on an overflowed
// result, cleared by IRQ_CLR (set wins).
//
// state  | meaning
// IDLE   | waiting for START with a nonzero CH_MASK
// SETTLE | 3 cycles flushing synchronizer/last flop after a mux change
// GATE   | GATE_TICKS cycles counting rising edges of the selected input
// STORE  | result published (FREQ_VALID high); pick next channel
module freq_scan_ctrl #(
   parameter int NUM_CH     = 4,
   parameter int GATE_TICKS = 10000,
   parameter int CNT_W      = 12,
   parameter int CH_W       = 2
) (
   input logic               CLK,
   input logic               RST,
   freq_scan_ctrl_if.slave   bus
);
   localparam int TMR_W = (GATE_TICKS > 4) ? $clog2(GATE_TICKS) : 2;
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(2);
   localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_TICKS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_STORE} state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [NUM_CH-1:0]  mask_q, mask_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               sync1_q, sync1_d, sync2_q, sync2_d, last_q, last_d;
   logic [CNT_W-1:0]   freq_q, freq_d;
   logic [CH_W-1:0]    ch_id_q, ch_id_d;
   logic               ovf_out_q, ovf_out_d;
   logic               freq_valid_q, freq_valid_d;
   logic               done_q, done_d;
   logic               irq_q, irq_d;

   logic [2**CH_W-1:0] in_ext;
   logic [CH_W-1:0]    low_ch, nxt_ch;
   logic               nxt_found;
   logic               edge_det;

   // Zero-pad so the mux index is always in range when 2**CH_W > NUM_CH.
   always_comb begin
      in_ext = '0;
      in_ext[NUM_CH-1:0] = bus.IN;
   end

   // Descending scans leave the lowest qualifying index in the result.
   always_comb begin
      low_ch    = '0;
      nxt_ch    = '0;
      nxt_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (bus.CH_MASK[i]) low_ch = CH_W'(i);
         if (mask_q[i] && (i > int'(ch_q))) begin
            nxt_found = 1'b1;
            nxt_ch    = CH_W'(i);
         end
      end
   end

   assign edge_det = sync2_q & ~last_q;

   always_comb begin
      state_d      = state_q;
      tmr_d        = tmr_q;
      mask_d       = mask_q;
      ch_d         = ch_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;
      freq_d       = freq_q;
      ch_id_d      = ch_id_q;
      ovf_out_d    = ovf_out_q;
      freq_valid_d = 1'b0;
      done_d       = 1'b0;
      sync1_d      = in_ext[ch_q];
      sync2_d      = sync1_q;
      last_d       = sync2_q;

      case (state_q)
         S_IDLE: begin
            if (bus.START && (|bus.CH_MASK)) begin
               mask_d  = bus.CH_MASK;
               ch_d    = low_ch;
               tmr_d   = SETTLE_LOAD;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (tmr_q == '0) begin
               tmr_d   = GATE_LOAD;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_GATE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_GATE: begin
            if (edge_det) begin
               if (cnt_q == '1) ovf_d = 1'b1;
               else             cnt_d = cnt_q + 1'b1;
            end
            if (tmr_q == '0) begin
               // Publish on entry to STORE so FREQ_VALID lines up with STORE.
               freq_d       = cnt_d;
               ch_id_d      = ch_q;
               ovf_out_d    = ovf_d;
               freq_valid_d = 1'b1;
               state_d      = S_STORE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_STORE: begin
            if (nxt_found) begin
               ch_d    = nxt_ch;
               tmr_d   = SETTLE_LOAD;
               state_d = S_SETTLE;
            end else if (bus.CONTINUOUS && (|bus.CH_MASK)) begin
               mask_d  = bus.CH_MASK;
               ch_d    = low_ch;
               tmr_d   = SETTLE_LOAD;
               state_d = S_SETTLE;
            end else begin
               mask_d  = bus.CONTINUOUS ? bus.CH_MASK : mask_q;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef FREQ_SCAN_IRQ_EN
      irq_d = irq_q;
      if (bus.IRQ_CLR) irq_d = 1'b0;
      if (done_d || (freq_valid_d && ovf_out_d)) irq_d = 1'b1;
`else
      irq_d = 1'b0;
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         tmr_q        <= '0;
         mask_q       <= '0;
         ch_q         <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         last_q       <= 1'b0;
         freq_q       <= '0;
         ch_id_q      <= '0;
         ovf_out_q    <= 1'b0;
         freq_valid_q <= 1'b0;
         done_q       <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         mask_q       <= mask_d;
         ch_q         <= ch_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         last_q       <= last_d;
         freq_q       <= freq_d;
         ch_id_q      <= ch_id_d;
         ovf_out_q    <= ovf_out_d;
         freq_valid_q <= freq_valid_d;
         done_q       <= done_d;
         irq_q        <= irq_d;
      end
   end

   assign bus.BUSY       = (state_q != S_IDLE);
   assign bus.FREQ       = freq_q;
   assign bus.CH_ID      = ch_id_q;
   assign bus.FREQ_VALID = freq_valid_q;
   assign bus.OVERFLOW   = ovf_out_q;
   assign bus.DONE       = done_q;
`ifdef FREQ_SCAN_IRQ_EN
   assign bus.IRQ        = irq_q;
`else
   logic unused_irq;
   assign unused_irq = irq_q;
`endif
endmodule

// File: tb/tb_freq_scan_ctrl.sv
module tb_freq_scan_ctrl;
   localparam int NUM_CH = 4;
   localparam int GATE   = 100;
   localparam int CNT_W  = 5;
   localparam int CH_W   = 2;

   typedef struct packed {
      logic [CH_W-1:0]  ch;
      logic [CNT_W-1:0] freq;
      logic             ovf;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   prev_v = 0;
   int   last_v = 0;
   int   per [NUM_CH] = '{2, 2, 2, 2};
   int   ph  [NUM_CH] = '{0, 0, 0, 0};
   exp_t sb[$];

   freq_scan_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) ifc ();

   freq_scan_ctrl #(.NUM_CH(NUM_CH), .GATE_TICKS(GATE), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (ifc)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, want);
      end
   endtask

   // Square-wave sources, one per channel, with programmable period.
   initial begin
      ifc.IN = '0;
      forever begin
         @(posedge CLK);
         #2;
         for (int i = 0; i < NUM_CH; i++) begin
            ph[i] = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
            ifc.IN[i] = (ph[i] < per[i] / 2);
         end
      end
   end

   // Scoreboard: every result pops one expectation.
   always @(negedge CLK) begin
      exp_t e;
      if (ifc.FREQ_VALID === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ch_id", 32'(ifc.CH_ID), 32'(e.ch));
            chk("freq", 32'(ifc.FREQ), 32'(e.freq));
            chk("overflow", 32'(ifc.OVERFLOW), 32'(e.ovf));
         end
         prev_v = last_v;
         last_v = cyc;
      end
      if (ifc.DONE === 1'b1) done_cnt++;
   end

   task automatic push(input int ch, input int f, input bit o);
      exp_t e;
      e.ch = CH_W'(ch);
      e.freq = CNT_W'(f);
      e.ovf = o;
      sb.push_back(e);
   endtask

   task automatic pulse_start();
      @(posedge CLK); #1 ifc.START = 1'b1;
      @(posedge CLK); #1 ifc.START = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (ifc.DONE !== 1'b1 && n < bound) begin
         @(negedge CLK);
         n++;
      end
      if (n >= bound) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1);
   end

   initial begin
      int d0;
      ifc.START = 1'b0;
      ifc.CONTINUOUS = 1'b0;
      ifc.CH_MASK = '0;
`ifdef FREQ_SCAN_IRQ_EN
      ifc.IRQ_CLR = 1'b0;
`endif
      idle_cycles(4);
      chk("rst_busy", 32'(ifc.BUSY), 0);
      chk("rst_freq", 32'(ifc.FREQ), 0);
      chk("rst_ch_id", 32'(ifc.CH_ID), 0);
      chk("rst_valid", 32'(ifc.FREQ_VALID), 0);
      chk("rst_ovf", 32'(ifc.OVERFLOW), 0);
      chk("rst_done", 32'(ifc.DONE), 0);
      RST = 1'b0;
      idle_cycles(3);

      // Single channel, latency check
      per[0] = 10;
      ifc.CH_MASK = 4'b0001;
      push(0, 10, 1'b0);
      pulse_start();
      chk("busy_T1", 32'(ifc.BUSY), 1);
      idle_cycles(102);
      chk("valid_early", 32'(ifc.FREQ_VALID), 0);
      idle_cycles(1);
      chk("valid_T104", 32'(ifc.FREQ_VALID), 1);
      idle_cycles(1);
      chk("done_T105", 32'(ifc.DONE), 1);
      chk("busy_after", 32'(ifc.BUSY), 0);
      chk("valid_pulse", 32'(ifc.FREQ_VALID), 0);
      idle_cycles(5);

      // Sparse mask 1010; channels 0 and 2 toggle but must not report
      per[0] = 2; per[1] = 4; per[2] = 6; per[3] = 20;
      ifc.CH_MASK = 4'b1010;
      push(1, 25, 1'b0);
      push(3, 5, 1'b0);
      pulse_start();
      wait_done(600);
      chk("gap_1010", 32'(last_v - prev_v), 32'(GATE + 4));
      idle_cycles(5);

      // Saturation
`ifdef FREQ_SCAN_IRQ_EN
      ifc.IRQ_CLR = 1'b1;
      idle_cycles(1);
      ifc.IRQ_CLR = 1'b0;
      chk("irq_cleared_pre", 32'(ifc.IRQ), 0);
`endif
      ifc.CH_MASK = 4'b0001;
      push(0, 31, 1'b1);
      pulse_start();
      wait_done(600);
      idle_cycles(5);
`ifdef FREQ_SCAN_IRQ_EN
      chk("irq_held", 32'(ifc.IRQ), 1);
      ifc.IRQ_CLR = 1'b1;
      idle_cycles(1);
      ifc.IRQ_CLR = 1'b0;
      chk("irq_cleared", 32'(ifc.IRQ), 0);
`endif

      // Continuous with mask change mid-gate, then drop CONTINUOUS
      per[0] = 10; per[2] = 5;
      ifc.CONTINUOUS = 1'b1;
      ifc.CH_MASK = 4'b0001;
      push(0, 10, 1'b0);
      push(2, 20, 1'b0);
      d0 = done_cnt;
      pulse_start();
      idle_cycles(50);
      ifc.CH_MASK = 4'b0100;
      idle_cycles(100);
      ifc.CONTINUOUS = 1'b0;
      wait_done(600);
      idle_cycles(150);
      chk("cont_done_cnt", 32'(done_cnt - d0), 1);
      chk("cont_gap", 32'(last_v - prev_v), 32'(GATE + 4));
      chk("cont_busy", 32'(ifc.BUSY), 0);

      // START with empty mask
      ifc.CH_MASK = 4'b0000;
      d0 = done_cnt;
      pulse_start();
      chk("zero_mask_busy", 32'(ifc.BUSY), 0);
      idle_cycles(10);
      chk("zero_mask_busy2", 32'(ifc.BUSY), 0);
      chk("zero_mask_done", 32'(done_cnt - d0), 0);

      // START while busy
      ifc.CH_MASK = 4'b0001;
      push(0, 10, 1'b0);
      d0 = done_cnt;
      pulse_start();
      idle_cycles(20);
      pulse_start();
      wait_done(600);
      idle_cycles(150);
      chk("busy_start_done", 32'(done_cnt - d0), 1);
      chk("busy_start_sb", 32'(sb.size()), 0);

      // Reset mid-gate
      pulse_start();
      idle_cycles(52);
      RST = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(ifc.BUSY), 0);
      chk("mid_rst_freq", 32'(ifc.FREQ), 0);
      chk("mid_rst_valid", 32'(ifc.FREQ_VALID), 0);
      chk("mid_rst_done", 32'(ifc.DONE), 0);
      idle_cycles(3);
      RST = 1'b0;
      idle_cycles(120);
      chk("post_rst_idle", 32'(ifc.BUSY), 0);
      ifc.CH_MASK = 4'b0100;
      push(2, 20, 1'b0);
      pulse_start();
      wait_done(600);
      idle_cycles(5);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
